// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the write-port arbiter.
// The arbiter drives the master modport; requesters and the FIFO model attach to slave.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int ID_W      = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         full;
    logic                         wr_en;
    logic [DATA_SIZE-1:0]         wr_data;
    logic [ID_W-1:0]              gnt_id;
    logic                         busy;

    modport master (
        input  req_valid,
        input  req_data,
        input  full,
        output req_ready,
        output wr_en,
        output wr_data,
        output gnt_id,
        output busy
    );

    modport slave (
        output req_valid,
        output req_data,
        output full,
        input  req_ready,
        input  wr_en,
        input  wr_data,
        input  gnt_id,
        input  busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the FIFO write port; one arbitration cycle per grant, then data passes combinationally.
// Back-pressure: full deasserts the granted req_ready and wr_en in the same cycle; the grant is held, not revoked.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int BURST_LEN = 4,
    parameter int ID_W      = 2
) (
    input  logic              wr_clk,
    input  logic              wr_rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]      last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic                 rr_found;
    logic [ID_W-1:0]      rr_pick;
    logic [ID_W-1:0]      rr_idx;
    logic                 vld_g;
    logic [DATA_SIZE-1:0] data_g;
    logic                 xfer;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 wr_en;
    logic [DATA_SIZE-1:0] wr_data;
    logic                 busy;

    // Rotating priority: scan starts one past the last grant and wraps.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = ID_W'((int'(last_gnt_q) + k) % NUM_REQ);
            if (!rr_found && bus.req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    always_comb begin
        vld_g  = 1'b0;
        data_g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt_id_q) begin
                vld_g  = bus.req_valid[i];
                data_g = bus.req_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = '0;
        xfer       = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    gnt_id_d   = rr_pick;
                    last_gnt_d = rr_pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                busy = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (ID_W'(i) == gnt_id_q) begin
                        req_ready[i] = ~bus.full;
                    end
                end
                xfer    = vld_g & ~bus.full;
                wr_en   = xfer;
                wr_data = xfer ? data_g : '0;
                // A dropped valid ends the grant even while full holds everything else.
                if (!vld_g) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q    <= IDLE;
            gnt_id_q   <= '0;
            last_gnt_q <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.wr_en     = wr_en;
    assign bus.wr_data   = wr_data;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Cycle vectors for the write-port arbiter, with written beats checked against a queue of expected data.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_SIZE = 8;
    localparam int BURST_LEN = 4;
    localparam int ID_W      = 2;

    logic wr_clk = 1'b0;
    logic wr_rst = 1'b1;
    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_SIZE(DATA_SIZE), .ID_W(ID_W)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_SIZE(DATA_SIZE),
        .BURST_LEN(BURST_LEN),
        .ID_W     (ID_W)
    ) dut (
        .wr_clk(wr_clk),
        .wr_rst(wr_rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        full;
        logic        en;
        logic [7:0]  wdat;
        logic [3:0]  rdy;
        logic [1:0]  gnt;
        logic        busy;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] vld, input logic [31:0] dat,
                       input logic full, input logic en, input logic [7:0] wdat,
                       input logic [3:0] rdy, input logic [1:0] gnt, input logic busy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dat = dat; v.full = full;
        v.en = en; v.wdat = wdat; v.rdy = rdy; v.gnt = gnt; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input logic rst, input logic [3:0] vld, input logic [31:0] dat,
                            input logic [1:0] gnt);
        add(rst, vld, dat, 1'b0, 1'b0, 8'h00, 4'b0000, gnt, 1'b0);
    endtask

    task automatic add_beat(input logic [3:0] vld, input logic [31:0] dat,
                            input logic [1:0] g, input logic [7:0] wdat);
        add(1'b0, vld, dat, 1'b0, 1'b1, wdat, 4'(1 << g), g, 1'b1);
    endtask

    // Every beat the DUT writes must be the next one the vectors expected.
    always @(negedge wr_clk) begin
        chk("wr_en_while_full", {31'd0, bus.wr_en & bus.full}, 32'd0);
        if (bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h expected no write", bus.wr_data);
            end else begin
                chk("sb_wr_data", {24'd0, bus.wr_data}, {24'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          b[4];
        logic [31:0] dat;
        logic [1:0]  prev;
        logic        seen;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.full      = 1'b0;

        // Reset held with arbitrary requests: outputs stay quiet.
        for (int i = 0; i < 3; i++) add_idle(1'b1, 4'($urandom), 32'($urandom), 2'd0);

        // req0 alone, six beats: burst of four, arbitration cycle, then the remaining two.
        add_idle(1'b0, 4'b0001, 32'h10, 2'd0);
        for (int i = 0; i < 4; i++) add_beat(4'b0001, 32'h10 + 32'(i), 2'd0, 8'(8'h10 + i));
        add_idle(1'b0, 4'b0001, 32'h14, 2'd0);
        add_beat(4'b0001, 32'h14, 2'd0, 8'h14);
        add_beat(4'b0001, 32'h15, 2'd0, 8'h15);
        add(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00, 4'b0001, 2'd0, 1'b1);
        add_idle(1'b0, 4'b0000, 32'h0, 2'd0);

        // All four valid after reset: grants 0,1,2,3,0, four beats each.
        add_idle(1'b1, 4'b0000, 32'h0, 2'd0);
        for (int i = 0; i < 4; i++) b[i] = 0;
        prev = 2'd0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) dat[i*8 +: 8] = 8'((i + 3) * 16 + b[i]);
            add_idle(1'b0, 4'b1111, dat, prev);
            for (int j = 0; j < 4; j++) begin
                for (int i = 0; i < 4; i++) dat[i*8 +: 8] = 8'((i + 3) * 16 + b[i]);
                add_beat(4'b1111, dat, 2'(k % 4), 8'(((k % 4) + 3) * 16 + b[k % 4]));
                b[k % 4]++;
            end
            prev = 2'(k % 4);
        end
        add_idle(1'b0, 4'b0000, 32'h0, 2'd0);

        // req2 stalled by full for three cycles after its second beat.
        add_idle(1'b0, 4'b0100, 32'h0050_0000, 2'd0);
        add_beat(4'b0100, 32'h0050_0000, 2'd2, 8'h50);
        add_beat(4'b0100, 32'h0051_0000, 2'd2, 8'h51);
        for (int i = 0; i < 3; i++)
            add(1'b0, 4'b0100, 32'h0052_0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b1);
        add_beat(4'b0100, 32'h0052_0000, 2'd2, 8'h52);
        add_beat(4'b0100, 32'h0053_0000, 2'd2, 8'h53);
        add_idle(1'b0, 4'b0000, 32'h0, 2'd2);

        // req1 drops valid after one beat; req2 wins next.
        add_idle(1'b1, 4'b0000, 32'h0, 2'd0);
        add_idle(1'b0, 4'b1110, 32'h8171_6100, 2'd0);
        add_beat(4'b1110, 32'h8171_6100, 2'd1, 8'h61);
        add(1'b0, 4'b1100, 32'h8171_0000, 1'b0, 1'b0, 8'h00, 4'b0010, 2'd1, 1'b1);
        add_idle(1'b0, 4'b1100, 32'h8171_0000, 2'd1);
        add_beat(4'b1100, 32'h8171_0000, 2'd2, 8'h71);
        add(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00, 4'b0100, 2'd2, 1'b1);
        add_idle(1'b0, 4'b0000, 32'h0, 2'd2);

        // Reset in the middle of req3's burst; req0 gets the first grant afterwards.
        add_idle(1'b0, 4'b1000, 32'h9000_0000, 2'd2);
        add_beat(4'b1000, 32'h9000_0000, 2'd3, 8'h90);
        add_beat(4'b1000, 32'h9100_0000, 2'd3, 8'h91);
        add_idle(1'b1, 4'b1001, 32'h9200_00A0, 2'd0);
        add_idle(1'b0, 4'b1001, 32'h9200_00A0, 2'd0);
        add_beat(4'b1001, 32'h9200_00A0, 2'd0, 8'hA0);
        add(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00, 4'b0001, 2'd0, 1'b1);
        add_idle(1'b0, 4'b0000, 32'h0, 2'd0);

        foreach (vecs[i]) begin
            @(posedge wr_clk);
            #1;
            wr_rst        = vecs[i].rst;
            bus.req_valid = vecs[i].vld;
            bus.req_data  = vecs[i].dat;
            bus.full      = vecs[i].full;
            #1;
            chk($sformatf("v%0d wr_en", i), {31'd0, bus.wr_en}, {31'd0, vecs[i].en});
            chk($sformatf("v%0d req_ready", i), {28'd0, bus.req_ready}, {28'd0, vecs[i].rdy});
            chk($sformatf("v%0d gnt_id", i), {30'd0, bus.gnt_id}, {30'd0, vecs[i].gnt});
            chk($sformatf("v%0d busy", i), {31'd0, bus.busy}, {31'd0, vecs[i].busy});
            if (vecs[i].en) sb.push_back(vecs[i].wdat);
            else chk($sformatf("v%0d wr_data_zero", i), {24'd0, bus.wr_data}, 32'd0);
        end

        // Grant taken while full is already high: held without writing until full drops.
        @(posedge wr_clk);
        #1;
        wr_rst = 1'b1;
        bus.req_valid = '0;
        @(posedge wr_clk);
        #1;
        wr_rst        = 1'b0;
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_C500;
        bus.full      = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge wr_clk);
            #2;
            chk("held_busy", {31'd0, bus.busy}, 32'd1);
            chk("held_no_write", {31'd0, bus.wr_en}, 32'd0);
            chk("held_gnt", {30'd0, bus.gnt_id}, 32'd1);
        end
        @(posedge wr_clk);
        #1;
        bus.full = 1'b0;
        sb.push_back(8'hC5);
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            #1;
            if (bus.wr_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge wr_clk);
        end
        chk("write_after_full_release", {31'd0, seen}, 32'd1);
        @(posedge wr_clk);
        #1;
        bus.req_valid = '0;
        @(posedge wr_clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
